// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory req/gnt/rvalid channel and the
// valid/ready queue head presented to decode.
interface fetch_unit_if #(
  parameter int Width = 32
);
  logic             imem_req;
  logic [Width-1:0] imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [31:0]      imem_rdata;

  logic             if_valid;
  logic [31:0]      if_instr;
  logic [Width-1:0] if_pc;
  logic             if_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output if_valid, if_instr, if_pc,
    input  if_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  if_valid, if_instr, if_pc,
    output if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: single-outstanding imem requests from the
// registered PC, returned {pc, instr} pairs buffered in a circular queue.
module fetch_unit #(
  parameter int Width = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] pc_current,
  output logic             pc_en,
  input  logic             flush,
  fetch_unit_if.master     bus
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [PtrW-1:0]  rd_ptr, wr_ptr;
  logic [CntW-1:0]  count;
  logic [Width-1:0] pending_pc;

  logic [Width-1:0] q_pc    [DEPTH];
  logic [31:0]      q_instr [DEPTH];

  logic full, accept, push, pop, head_valid;

  assign full       = (count == CntW'(DEPTH));
  assign head_valid = reset && (count != '0);

  assign bus.imem_req  = reset && (state == IDLE) && !full && !flush;
  assign bus.imem_addr = pc_current;
  assign accept        = bus.imem_req && bus.imem_gnt;
  assign pc_en         = reset && (accept || flush);

  // A response landing together with a flush belongs to the old path and is dropped.
  assign push = reset && (state == WAIT) && bus.imem_rvalid && !flush;
  assign pop  = head_valid && bus.if_ready && !flush;

  assign bus.if_valid = head_valid;
  assign bus.if_instr = q_instr[rd_ptr];
  assign bus.if_pc    = q_pc[rd_ptr];

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = WAIT;
      end
      WAIT: begin
        if (flush)                 state_nxt = bus.imem_rvalid ? IDLE : DRAIN;
        else if (bus.imem_rvalid)  state_nxt = IDLE;
      end
      DRAIN: begin
        if (bus.imem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      pending_pc <= '0;
    end else begin
      state <= state_nxt;
      if (accept) pending_pc <= pc_current;
      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: queue storage is not reset; count gates visibility through if_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= pending_pc;
      q_instr[wr_ptr] <= bus.imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, backpressure, grant stall,
// flush while outstanding and flush coinciding with rvalid and pop.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        pc_en;
  logic [31:0] pc;
  logic [31:0] target;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit_if #(.Width(32)) bus ();

  fetch_unit #(.Width(32), .DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_current (pc),
    .pc_en      (pc_en),
    .flush      (flush),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // PC register with its next-PC mux: redirect target on flush, else pc+4.
  always_ff @(posedge clk) begin
    if (!reset)     pc <= '0;
    else if (pc_en) pc <= flush ? target : pc + 32'd4;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic f, input logic g, input logic rv,
                       input logic [31:0] rd, input logic rdy);
    @(negedge clk);
    flush           = f;
    bus.imem_gnt    = g;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    bus.if_ready    = rdy;
    #1;
  endtask

  task automatic exp_bus(input string tag, input logic req, input logic [31:0] addr,
                         input logic en);
    check({tag, ".req"},   {31'd0, bus.imem_req}, {31'd0, req});
    check({tag, ".addr"},  bus.imem_addr, addr);
    check({tag, ".pc_en"}, {31'd0, pc_en}, {31'd0, en});
  endtask

  task automatic exp_q(input string tag, input logic v, input logic [31:0] epc,
                       input logic [31:0] einstr);
    check({tag, ".valid"}, {31'd0, bus.if_valid}, {31'd0, v});
    if (v) begin
      check({tag, ".pc"},    bus.if_pc, epc);
      check({tag, ".instr"}, bus.if_instr, einstr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset           = 1'b0;
    flush           = 1'b0;
    target          = '0;
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = '0;
    bus.if_ready    = 1'b0;

    // Reset held with gnt and rvalid active
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 32'h0, 0);
      exp_bus("rst", 0, 32'h0, 0);
      exp_q("rst", 0, 0, 0);
    end

    @(negedge clk);
    reset           = 1'b1;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    #1;
    exp_bus("release", 1, 32'h0, 0);
    exp_q("release", 0, 0, 0);

    // Zero-wait stream, decode always ready
    drive(0, 1, 0, 32'h0, 1);        exp_bus("s0_acc", 1, 32'h0, 1);  exp_q("s0_acc", 0, 0, 0);
    drive(0, 1, 1, 32'h00000013, 1); exp_bus("s0_rv", 0, 32'h4, 0);   exp_q("s0_rv", 0, 0, 0);
    drive(0, 1, 0, 32'h0, 1);        exp_bus("s1_acc", 1, 32'h4, 1);  exp_q("s1_acc", 1, 32'h0, 32'h00000013);
    drive(0, 1, 1, 32'h00100093, 1); exp_bus("s1_rv", 0, 32'h8, 0);   exp_q("s1_rv", 0, 0, 0);
    drive(0, 1, 0, 32'h0, 1);        exp_bus("s2_acc", 1, 32'h8, 1);  exp_q("s2_acc", 1, 32'h4, 32'h00100093);
    drive(0, 1, 1, 32'h00200113, 1); exp_bus("s2_rv", 0, 32'hC, 0);   exp_q("s2_rv", 0, 0, 0);
    drive(0, 1, 0, 32'h0, 1);        exp_bus("s3_acc", 1, 32'hC, 1);  exp_q("s3_acc", 1, 32'h8, 32'h00200113);
    drive(0, 1, 1, 32'h00300193, 1); exp_bus("s3_rv", 0, 32'h10, 0);  exp_q("s3_rv", 0, 0, 0);

    // Grant stall at 0x10
    drive(0, 0, 0, 32'h0, 1); exp_bus("gs0", 1, 32'h10, 0); exp_q("gs0", 1, 32'hC, 32'h00300193);
    drive(0, 0, 0, 32'h0, 1); exp_bus("gs1", 1, 32'h10, 0); exp_q("gs1", 0, 0, 0);
    drive(0, 0, 0, 32'h0, 1); exp_bus("gs2", 1, 32'h10, 0);
    drive(0, 1, 0, 32'h0, 0); exp_bus("gs_acc", 1, 32'h10, 1);
    drive(0, 1, 0, 32'h0, 0); exp_bus("gs_wait", 0, 32'h14, 0);
    drive(0, 1, 1, 32'h00400213, 0); exp_bus("gs_rv", 0, 32'h14, 0); exp_q("gs_rv", 0, 0, 0);

    // Backpressure until the queue fills
    drive(0, 1, 0, 32'h0, 0);        exp_bus("bp_acc", 1, 32'h14, 1); exp_q("bp_acc", 1, 32'h10, 32'h00400213);
    drive(0, 1, 1, 32'h00500293, 0); exp_bus("bp_rv", 0, 32'h18, 0);  exp_q("bp_rv", 1, 32'h10, 32'h00400213);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 32'h0, 0);
      exp_bus("bp_full", 0, 32'h18, 0);
      exp_q("bp_full", 1, 32'h10, 32'h00400213);
    end
    drive(0, 1, 0, 32'h0, 1); exp_bus("bp_pop", 0, 32'h18, 0); exp_q("bp_pop", 1, 32'h10, 32'h00400213);
    drive(0, 0, 0, 32'h0, 0); exp_bus("bp_reissue", 1, 32'h18, 0); exp_q("bp_reissue", 1, 32'h14, 32'h00500293);

    // Drain queue while fetching up to 0x20
    drive(0, 1, 0, 32'h0, 1);        exp_bus("d0_acc", 1, 32'h18, 1); exp_q("d0_acc", 1, 32'h14, 32'h00500293);
    drive(0, 1, 1, 32'h00600313, 0); exp_bus("d0_rv", 0, 32'h1C, 0);  exp_q("d0_rv", 0, 0, 0);
    drive(0, 1, 0, 32'h0, 1);        exp_bus("d1_acc", 1, 32'h1C, 1); exp_q("d1_acc", 1, 32'h18, 32'h00600313);
    drive(0, 1, 1, 32'h00700393, 0); exp_bus("d1_rv", 0, 32'h20, 0);
    drive(0, 1, 0, 32'h0, 1);        exp_bus("d2_acc", 1, 32'h20, 1); exp_q("d2_acc", 1, 32'h1C, 32'h00700393);

    // Flush while 0x20 is outstanding, stale response two cycles later
    target = 32'h100;
    drive(1, 1, 0, 32'h0, 1);        exp_bus("fl", 0, 32'h24, 1);       exp_q("fl", 0, 0, 0);
    drive(0, 1, 0, 32'h0, 1);        exp_bus("fl_drain", 0, 32'h100, 0); exp_q("fl_drain", 0, 0, 0);
    drive(0, 1, 1, 32'hDEADBEEF, 1); exp_bus("fl_rv", 0, 32'h100, 0);    exp_q("fl_rv", 0, 0, 0);
    drive(0, 0, 0, 32'h0, 1);        exp_bus("fl_idle", 1, 32'h100, 0);  exp_q("fl_idle", 0, 0, 0);
    drive(0, 0, 0, 32'h0, 1);        exp_q("fl_empty", 0, 0, 0);

    // Flush coinciding with rvalid and a pop at count=1
    drive(0, 1, 0, 32'h0, 0);        exp_bus("sim_acc0", 1, 32'h100, 1);
    drive(0, 1, 1, 32'h11111111, 0); exp_bus("sim_rv0", 0, 32'h104, 0);
    drive(0, 1, 0, 32'h0, 0);        exp_bus("sim_acc1", 1, 32'h104, 1); exp_q("sim_acc1", 1, 32'h100, 32'h11111111);
    target = 32'h200;
    drive(1, 1, 1, 32'h0BADC0DE, 1); exp_bus("sim_fl", 0, 32'h108, 1);   exp_q("sim_fl", 1, 32'h100, 32'h11111111);
    drive(0, 0, 1, 32'hCAFEF00D, 1); exp_bus("sim_after", 1, 32'h200, 0); exp_q("sim_after", 0, 0, 0);

    // Normal fetch resumes on the redirected path; stray rvalid above was ignored
    drive(0, 1, 0, 32'h0, 1);        exp_bus("rd_acc", 1, 32'h200, 1);   exp_q("rd_acc", 0, 0, 0);
    drive(0, 1, 1, 32'h22222222, 1); exp_bus("rd_rv", 0, 32'h204, 0);    exp_q("rd_rv", 0, 0, 0);
    drive(0, 0, 0, 32'h0, 1);        exp_bus("rd_head", 1, 32'h204, 0);  exp_q("rd_head", 1, 32'h200, 32'h22222222);
    drive(0, 0, 0, 32'h0, 0);        exp_q("rd_popped", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end for the 3-stage pipeline. It reads the registered PC, issues single-outstanding requests to instruction memory over a req/gnt/rvalid interface, and buffers returned {pc, instr} pairs in a small queue feeding decode. It is the sole driver of the PC register's enable, advancing the PC only when a fetch is accepted or a redirect occurs.

## Interface
- Width, 32, PC and address width
- DEPTH, 2, fetch queue entries (power of 2, ≥2)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset (reset==0 resets on the next rising clk)
- pc_current  in  Width  registered PC value
- pc_en  out  1  enable to PC register; PC loads next-PC mux output when high
- flush  in  1  branch/jump redirect from execute; next-PC mux presents target this cycle
- imem_req  out  1  fetch request
- imem_addr  out  Width  fetch address, equals pc_current
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  instruction word
- if_valid  out  1  queue head valid
- if_instr  out  32  queue head instruction
- if_pc  out  Width  queue head PC
- if_ready  in  1  decode consumes head this cycle

## Operation
- States: IDLE (no outstanding request), WAIT (one request granted, response pending), DRAIN (flushed while outstanding; next response is discarded).
- Queue: circular buffer, rd_ptr/wr_ptr of log2(DEPTH) bits wrapping at DEPTH, count 0..DEPTH.
- imem_req = reset && state==IDLE && count<DEPTH && !flush. imem_addr = pc_current always.
- Accept = imem_req && imem_gnt: latch pending_pc <= pc_current; IDLE→WAIT.
- pc_en = accept || flush (combinational). On flush the PC loads the redirect target.
- WAIT && imem_rvalid && !flush: push {pending_pc, imem_rdata} at wr_ptr; WAIT→IDLE. Slot guaranteed: count<DEPTH was checked at issue and count cannot increase while in WAIT.
- Pop = if_valid && if_ready: advance rd_ptr. Push and pop in the same cycle: count unchanged.
- if_valid = count!=0; if_instr/if_pc driven from rd_ptr entry.
- imem_rvalid in IDLE is ignored.
- Flush (highest priority):
  - count, rd_ptr, wr_ptr <= 0; no push; a concurrent pop is absorbed.
  - imem_req forced 0.
  - WAIT with no rvalid this cycle → DRAIN.
  - WAIT with rvalid this cycle → response discarded; → IDLE.
  - DRAIN stays DRAIN; IDLE stays IDLE.
- DRAIN: on imem_rvalid, discard → IDLE. imem_req = 0 throughout.

## Timing
- Reset values: state IDLE, count 0, pointers 0, pending_pc 0; if_valid 0, imem_req 0, pc_en 0 while reset==0.
- First request: imem_req asserts in the first cycle after reset deasserts, with imem_addr = pc_current.
- imem_req stays asserted and imem_addr stays stable until gnt, flush, or queue full.
- pc_current reflects the advanced PC one cycle after pc_en.
- Zero-wait memory (gnt same cycle, rvalid next cycle): fetch rate is 1 instruction per 2 cycles. The instruction appears on if_valid the cycle after rvalid.
- Any rvalid received in DRAIN, and any rvalid coinciding with flush, never reaches the queue.

## Test plan
- Reset: hold reset=0 for 3 cycles with imem_gnt=1 and imem_rvalid=1 → if_valid=0, imem_req=0, pc_en=0. Release with pc_current=0 → imem_req=1, imem_addr=0 in the next cycle.
- Stream: zero-wait memory returning 0x00000013, 0x00100093, 0x00200113 for PCs 0, 4, 8, with if_ready=1 → if_pc/if_instr emerge in order, one every 2 cycles, with one pc_en pulse per accept.
- Backpressure: if_ready=0, DEPTH=2 → after 2 entries queued, imem_req=0 and pc_en=0 indefinitely. Set if_ready=1 → head pops and imem_req reasserts in the same cycle that count drops below 2.
- Grant stall: imem_gnt=0 for 3 cycles → imem_req=1 and imem_addr=0x10 stable, pc_en=0. gnt=1 → single pc_en pulse, then WAIT.
- Flush mid-flight: request 0x20 granted; flush next cycle with redirect 0x100; rvalid with 0xDEADBEEF two cycles later → pc_en=1 on flush, 0xDEADBEEF is never visible, if_valid=0, next imem_addr=0x100.
- Simultaneous events: flush in the same cycle as rvalid and an if_ready pop with count=1 → count=0, response dropped, state IDLE, and a request for the redirect PC is issued in the following cycle.
